// File: rtl/hid_arb_pkg.sv
// Shared types and width helpers for the HID report arbiter.
package hid_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_e;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // A silence counter only has to reach cycles-1, so clog2(cycles) bits suffice.
    function automatic int timeout_width(input int cycles);
        return clog2(cycles);
    endfunction

    localparam int C_TIMEOUT_CYCLES_DFLT = 6000000;
    localparam int TIMEOUT_W_DFLT        = timeout_width(C_TIMEOUT_CYCLES_DFLT);

endpackage

// File: rtl/hid_port_slot.sv
// One-entry report slot for a single HID host: newest-wins capture, duplicate
// suppression against the last written report, overrun flag, and the silence
// timer that blanks the display when a device goes away.
module hid_port_slot
    import hid_arb_pkg::*;
#(
    parameter int C_report_bytes   = 8,
    parameter int C_timeout_cycles = 6000000,
    parameter int C_dedup          = 1
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          hid_valid_i,
    input  logic [C_report_bytes*8-1:0]   hid_report_i,
    input  logic                          grant_i,
    input  logic                          wr_done_i,
    input  logic [C_report_bytes*8-1:0]   wr_data_i,
    input  logic                          clear_i,
    output logic [C_report_bytes*8-1:0]   slot_o,
    output logic                          pending_o,
    output logic                          alive_o,
    output logic                          overrun_o
);

    localparam int R  = C_report_bytes * 8;
    localparam int TW = timeout_width(C_timeout_cycles);
    localparam logic [TW-1:0] CNT_MAX = TW'(C_timeout_cycles - 1);
    localparam logic [TW-1:0] CNT_PRE = TW'(C_timeout_cycles - 2);

    logic [R-1:0]  slot_q, slot_d;
    logic [R-1:0]  last_q, last_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic          alive_q, alive_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic dup;
    logic accept;
    logic timeout_hit;

    // Silence timer: a strobe restarts it, otherwise count up and saturate.
    // The port dies on the edge where the count reaches CNT_MAX.
    always_comb begin
        cnt_d       = cnt_q;
        alive_d     = alive_q;
        timeout_hit = alive_q && !hid_valid_i && (cnt_q == CNT_PRE);
        if (hid_valid_i) begin
            cnt_d   = '0;
            alive_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + TW'(1);
        end
        if (timeout_hit) begin
            alive_d = 1'b0;
        end
    end

    // Capture, dedup, overrun and last-written bookkeeping.
    // A fresh capture outranks the grant that clears pending in the same cycle;
    // the grant already took the old slot contents, so that is not an overrun.
    always_comb begin
        slot_d    = slot_q;
        last_d    = last_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        dup       = (C_dedup != 0) && alive_q && (hid_report_i == last_q);
        accept    = hid_valid_i && !dup;

        if (grant_i) begin
            pending_d = 1'b0;
        end
        if (accept) begin
            slot_d    = hid_report_i;
            pending_d = 1'b1;
        end else if (timeout_hit) begin
            slot_d    = '0;
            pending_d = 1'b1;
        end

        if (clear_i) begin
            overrun_d = 1'b0;
        end
        if (accept && pending_q && !grant_i) begin
            overrun_d = 1'b1;
        end

        if (wr_done_i) begin
            last_d = wr_data_i;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            slot_q    <= '0;
            last_q    <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            alive_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            slot_q    <= slot_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            alive_q   <= alive_d;
            cnt_q     <= cnt_d;
        end
    end

    assign slot_o    = slot_q;
    assign pending_o = pending_q;
    assign alive_o   = alive_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/hid_report_arbiter.sv
// Shares one report write port between several HID host instances.
// Each port owns a slot (hid_port_slot); this level only does the round-robin
// pick and the offer/handshake FSM.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ARB_IDLE  | no offer outstanding; grant the next pending slot if any
// ARB_OFFER | wr_valid_o high, port/data frozen until wr_ready_i
module hid_report_arbiter
    import hid_arb_pkg::*;
#(
    parameter int C_ports          = 2,
    parameter int C_report_bytes   = 8,
    parameter int C_timeout_cycles = 6000000,
    parameter int C_dedup          = 1
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic [C_ports-1:0]                  hid_valid_i,
    input  logic [C_ports*C_report_bytes*8-1:0] hid_report_i,
    output logic                                wr_valid_o,
    input  logic                                wr_ready_i,
    output logic [clog2(C_ports)-1:0]           wr_port_o,
    output logic [C_report_bytes*8-1:0]         wr_data_o,
    output logic [C_ports-1:0]                  port_alive_o,
    output logic [C_ports-1:0]                  overrun_o,
    input  logic                                clear_i
);

    localparam int R  = C_report_bytes * 8;
    localparam int PW = clog2(C_ports);

    arb_state_e           state_q, state_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [PW-1:0]        wr_port_q, wr_port_d;
    logic [R-1:0]         wr_data_q, wr_data_d;
    logic [PW-1:0]        last_grant_q, last_grant_d;

    logic [C_ports-1:0][R-1:0] slot_w;
    logic [C_ports-1:0]        pending_w;
    logic [C_ports-1:0]        grant_w;
    logic [C_ports-1:0]        done_w;

    logic                 pick_found;
    logic [PW-1:0]        pick_idx;
    logic [PW:0]          rr_sum;
    logic [PW-1:0]        rr_idx;

    for (genvar p = 0; p < C_ports; p++) begin : g_port
        hid_port_slot #(
            .C_report_bytes  (C_report_bytes),
            .C_timeout_cycles(C_timeout_cycles),
            .C_dedup         (C_dedup)
        ) u_slot (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .hid_valid_i (hid_valid_i[p]),
            .hid_report_i(hid_report_i[p*R +: R]),
            .grant_i     (grant_w[p]),
            .wr_done_i   (done_w[p]),
            .wr_data_i   (wr_data_q),
            .clear_i     (clear_i),
            .slot_o      (slot_w[p]),
            .pending_o   (pending_w[p]),
            .alive_o     (port_alive_o[p]),
            .overrun_o   (overrun_o[p])
        );
    end

    // Round-robin pick: first pending port after last_grant, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        rr_sum     = '0;
        rr_idx     = '0;
        for (int i = 1; i <= C_ports; i++) begin
            rr_sum = {1'b0, last_grant_q} + (PW+1)'(i);
            if (rr_sum >= (PW+1)'(C_ports)) begin
                rr_sum = rr_sum - (PW+1)'(C_ports);
            end
            rr_idx = rr_sum[PW-1:0];
            if (!pick_found && pending_w[rr_idx]) begin
                pick_found = 1'b1;
                pick_idx   = rr_idx;
            end
        end
    end

    // State and offer registers; reset drops any offer at once.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ARB_IDLE;
            wr_valid_q   <= 1'b0;
            wr_port_q    <= '0;
            wr_data_q    <= '0;
            last_grant_q <= PW'(C_ports - 1);
        end else begin
            state_q      <= state_d;
            wr_valid_q   <= wr_valid_d;
            wr_port_q    <= wr_port_d;
            wr_data_q    <= wr_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (pick_found) state_d = ARB_OFFER;
            ARB_OFFER: if (wr_ready_i) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Offer loading, grant/done strobes to the slots, last_grant update.
    always_comb begin
        wr_valid_d   = wr_valid_q;
        wr_port_d    = wr_port_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        grant_w      = '0;
        done_w       = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    wr_valid_d        = 1'b1;
                    wr_port_d         = pick_idx;
                    wr_data_d         = slot_w[pick_idx];
                    grant_w[pick_idx] = 1'b1;
                end
            end
            ARB_OFFER: begin
                if (wr_ready_i) begin
                    wr_valid_d        = 1'b0;
                    last_grant_d      = wr_port_q;
                    done_w[wr_port_q] = 1'b1;
                end
            end
            default: begin
                wr_valid_d = 1'b0;
            end
        endcase
    end

    assign wr_valid_o = wr_valid_q;
    assign wr_port_o  = wr_port_q;
    assign wr_data_o  = wr_data_q;

endmodule
